// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues one word read at a time to a
// stalling memory and queues returned {pc, inst} pairs for decode.
module fetch_queue #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [15:0] inst_pc_nx,
  input  logic        inst_ready,
  output logic        err
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT       = 2'd1,
    FLUSH_WAIT = 2'd2,
    HALTED     = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [15:0]   fpc_r, fpc_s;
  logic [15:0]   req_pc_r, req_pc_s;
  logic [15:0]   pc_q_r   [QDEPTH];
  logic [15:0]   inst_q_r [QDEPTH];
  logic [AW-1:0] head_r, tail_r;
  logic [CW-1:0] count_r;
  logic          halt_r, err_r;
  logic          issue_s, push_s, pop_s, flush_s, err_det_s;
  logic [15:0]   redir_pc_s;

  assign redir_pc_s = {redirect_pc[15:1], 1'b0};
  // A redirect while halted is ignored entirely, including its flush.
  assign flush_s    = redirect && (state_r != HALTED);
  assign pop_s      = (count_r != '0) && inst_ready && !flush_s;
  assign err_det_s  = (mem_done && ((state_r == IDLE) || (state_r == HALTED)))
                    || (redirect && redirect_pc[0]);

  // Next-state, issue and push decisions.
  always_comb begin
    state_s  = state_r;
    fpc_s    = fpc_r;
    req_pc_s = req_pc_r;
    issue_s  = 1'b0;
    push_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush_s) begin
          fpc_s = redir_pc_s;
        end else if (halt_r) begin
          state_s = HALTED;
        end else if (count_r < CNT_FULL) begin
          issue_s = 1'b1;
          if (!mem_stall) begin
            req_pc_s = fpc_r;
            fpc_s    = fpc_r + 16'd2;
            state_s  = WAIT;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (flush_s) begin
          fpc_s = redir_pc_s;
          // A response landing with the redirect is already gone; nothing left to discard.
          state_s = mem_done ? IDLE : FLUSH_WAIT;
        end else if (mem_done) begin
          push_s  = 1'b1;
          state_s = halt_r ? HALTED : IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      FLUSH_WAIT: begin
        if (flush_s) begin
          fpc_s = redir_pc_s;
        end else begin
          fpc_s = fpc_r;
        end
        if (mem_done) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH_WAIT;
        end
      end
      HALTED: begin
        state_s = HALTED;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state, pointers and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      fpc_r    <= 16'h0000;
      req_pc_r <= 16'h0000;
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      halt_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      fpc_r    <= fpc_s;
      req_pc_r <= req_pc_s;
      halt_r   <= halt_r | halt;
      err_r    <= err_r | err_det_s;
      if (flush_s) begin
        count_r <= '0;
        head_r  <= tail_r;
      end else begin
        if (push_s) tail_r <= tail_r + PTR_ONE;
        if (pop_s)  head_r <= head_r + PTR_ONE;
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Buffer storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        pc_q_r[i]   <= 16'h0000;
        inst_q_r[i] <= 16'h0000;
      end
    end else if (push_s) begin
      pc_q_r[tail_r]   <= req_pc_r;
      inst_q_r[tail_r] <= mem_data;
    end
  end

  assign mem_rd     = issue_s && !rst;
  assign mem_addr   = rst ? 16'h0000 : fpc_r;
  assign inst_valid = (count_r != '0);
  assign inst       = inst_q_r[head_r];
  assign inst_pc    = pc_q_r[head_r];
  assign inst_pc_nx = pc_q_r[head_r] + 16'd2;
  assign err        = err_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a bench-side memory model answers accepted
// reads, expected {pc, inst} pairs are queued on delivery and compared on each pop.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_nx;
  logic        inst_ready;
  logic        err;

  fetch_queue #(.QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_data(mem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_pc_nx(inst_pc_nx), .inst_ready(inst_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] addr_log[$];
  int          total = 0;
  int          bad = 0;
  int          accepts, pops, cd, mem_lat;
  bit          out_busy, delivering, flushed, tb_halted;
  logic [15:0] out_addr, dl_addr, last_pop_pc;
  logic        s_mem_rd, s_inst_valid, s_err;
  logic [15:0] s_mem_addr, s_inst, s_inst_pc, s_inst_pc_nx;

  function automatic logic [15:0] memword(input logic [15:0] a);
    logic [15:0] k;
    k = {1'b0, a[15:1]} + 16'd1;
    return 16'h1111 * k;
  endfunction

  // One clock: sample at negedge, score pops/pushes/accepts, then drive memory response.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    s_mem_rd = mem_rd; s_mem_addr = mem_addr; s_inst_valid = inst_valid; s_err = err;
    s_inst = inst; s_inst_pc = inst_pc; s_inst_pc_nx = inst_pc_nx;
    if (!rst) begin
      if (inst_valid && inst_ready && !(redirect && !tb_halted)) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got inst=%h pc=%h, required no valid entry", inst, inst_pc);
        end else begin
          e = sb.pop_front();
          pops++;
          last_pop_pc = inst_pc;
          if ({inst, inst_pc, inst_pc_nx} !== {e.ins, e.pc, e.pc + 16'd2}) begin
            bad++;
            $display("FAIL pop_entry: got inst=%h pc=%h nx=%h, required inst=%h pc=%h nx=%h",
                     inst, inst_pc, inst_pc_nx, e.ins, e.pc, e.pc + 16'd2);
          end
        end
      end
      if (redirect && !tb_halted) begin
        sb.delete();
        if (out_busy) flushed = 1'b1;
      end
      if (delivering) begin
        if (flushed) begin
          flushed = 1'b0;
        end else if (!(redirect && !tb_halted)) begin
          e.pc = dl_addr;
          e.ins = memword(dl_addr);
          sb.push_back(e);
        end
      end
      if (mem_rd && !mem_stall) begin
        out_busy = 1'b1; out_addr = mem_addr; cd = mem_lat;
        accepts++;
        addr_log.push_back(mem_addr);
      end
    end
    @(posedge clk);
    #1;
    mem_done = 1'b0;
    delivering = 1'b0;
    if (out_busy) begin
      if (cd <= 1) begin
        mem_done = 1'b1; mem_data = memword(out_addr); dl_addr = out_addr;
        delivering = 1'b1; out_busy = 1'b0;
      end else begin
        cd = cd - 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    mem_stall = 1'b0; inst_ready = 1'b0; mem_done = 1'b0; mem_data = 16'h0000;
    out_busy = 1'b0; delivering = 1'b0; flushed = 1'b0; tb_halted = 1'b0; mem_lat = 1;
    sb.delete(); addr_log.delete(); accepts = 0; pops = 0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (s_mem_rd !== 1'b0) begin bad++; $display("FAIL rst_mem_rd: got %b, required 0", s_mem_rd); end
    total++; if (s_mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_mem_addr: got %h, required 0000", s_mem_addr); end
    total++; if (s_inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid: got %b, required 0", s_inst_valid); end
    total++; if ({s_inst, s_inst_pc, s_inst_pc_nx} !== {16'h0000, 16'h0000, 16'h0002}) begin
      bad++; $display("FAIL rst_head: got inst=%h pc=%h nx=%h, required 0000/0000/0002", s_inst, s_inst_pc, s_inst_pc_nx); end
    total++; if (s_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b, required 0", s_err); end
    cycle();
    total++; if ({s_mem_rd, s_mem_addr} !== {1'b1, 16'h0000}) begin
      bad++; $display("FAIL first_issue: got rd=%b addr=%h, required 1/0000", s_mem_rd, s_mem_addr); end
    total++; if ({s_inst_valid, s_err} !== 2'b00) begin
      bad++; $display("FAIL post_rst_flags: got valid=%b err=%b, required 0/0", s_inst_valid, s_err); end
  endtask

  task automatic test_basic();
    int first_v;
    logic [15:0] fi, fp, fn;
    do_reset();
    inst_ready = 1'b1;
    first_v = -1;
    for (int i = 0; i < 40 && accepts < 3; i++) begin
      cycle();
      if (s_inst_valid && first_v < 0) begin
        first_v = i; fi = s_inst; fp = s_inst_pc; fn = s_inst_pc_nx;
      end
    end
    total++;
    if (accepts < 3) begin bad++; $display("FAIL basic_timeout: got %0d accepts, required 3", accepts); end
    else if ({addr_log[0], addr_log[1], addr_log[2]} !== {16'h0000, 16'h0002, 16'h0004}) begin
      bad++; $display("FAIL basic_addrs: got %h %h %h, required 0000 0002 0004", addr_log[0], addr_log[1], addr_log[2]); end
    total++; if (first_v !== 2) begin bad++; $display("FAIL basic_latency: got %0d, required 2", first_v); end
    total++; if ({fi, fp, fn} !== {16'h1111, 16'h0000, 16'h0002}) begin
      bad++; $display("FAIL basic_first: got inst=%h pc=%h nx=%h, required 1111/0000/0002", fi, fp, fn); end
    for (int i = 0; i < 4; i++) cycle();
    total++; if (pops < 2) begin bad++; $display("FAIL basic_pops: got %0d, required >=2", pops); end
  endtask

  task automatic test_stall();
    do_reset();
    inst_ready = 1'b1;
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if ({s_mem_rd, s_mem_addr} !== {1'b1, 16'h0000}) begin
        bad++; $display("FAIL stall_hold%0d: got rd=%b addr=%h, required 1/0000", i, s_mem_rd, s_mem_addr); end
    end
    mem_stall = 1'b0;
    cycle();
    total++; if ({s_mem_rd, s_mem_addr} !== {1'b1, 16'h0000}) begin
      bad++; $display("FAIL stall_accept: got rd=%b addr=%h, required 1/0000", s_mem_rd, s_mem_addr); end
    total++; if (accepts !== 1) begin bad++; $display("FAIL stall_count: got %0d accepts, required 1", accepts); end
    for (int i = 0; i < 20 && accepts < 2; i++) cycle();
    total++; if (accepts < 2 || addr_log[1] !== 16'h0002) begin
      bad++; $display("FAIL stall_next: got accepts=%0d addr=%h, required 2/0002", accepts, addr_log[1]); end
  endtask

  task automatic test_full();
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    total++; if (accepts !== 4) begin bad++; $display("FAIL full_issues: got %0d, required 4", accepts); end
    total++; if (s_mem_rd !== 1'b0) begin bad++; $display("FAIL full_rd: got %b, required 0", s_mem_rd); end
    total++; if (sb.size() !== 4) begin bad++; $display("FAIL full_entries: got %0d, required 4", sb.size()); end
    inst_ready = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    total++; if (pops < 4 || accepts <= 4) begin
      bad++; $display("FAIL full_resume: got pops=%0d accepts=%0d, required >=4 and >4", pops, accepts); end
  endtask

  task automatic test_redirect();
    int p0;
    do_reset();
    inst_ready = 1'b0;
    mem_lat = 3;
    for (int i = 0; i < 60 && accepts < 4; i++) cycle();
    total++; if (accepts < 4 || addr_log[3] !== 16'h0006) begin
      bad++; $display("FAIL redir_setup: got accepts=%0d addr=%h, required 4/0006", accepts, addr_log[3]); end
    redirect = 1'b1; redirect_pc = 16'h0040;
    cycle();
    redirect = 1'b0;
    total++; if (s_mem_rd !== 1'b0) begin bad++; $display("FAIL redir_wait_rd: got %b, required 0", s_mem_rd); end
    cycle();
    total++; if (s_inst_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_drop: got %b, required 0", s_inst_valid); end
    for (int i = 0; i < 20 && accepts < 5; i++) cycle();
    total++; if (accepts < 5 || addr_log[4] !== 16'h0040) begin
      bad++; $display("FAIL redir_addr: got accepts=%0d addr=%h, required 5/0040", accepts, addr_log[4]); end
    inst_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 20 && pops == p0; i++) cycle();
    total++; if (pops == p0 || last_pop_pc !== 16'h0040) begin
      bad++; $display("FAIL redir_first_pc: got pops=%0d pc=%h, required 1/0040", pops - p0, last_pop_pc); end
  endtask

  task automatic test_halt();
    int rd_seen;
    do_reset();
    inst_ready = 1'b0;
    mem_lat = 2;
    for (int i = 0; i < 30 && accepts < 2; i++) cycle();
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    cycle();
    mem_stall = 1'b1;
    rd_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_mem_rd !== 1'b0) rd_seen++;
    end
    total++; if (rd_seen !== 0 || accepts !== 2) begin
      bad++; $display("FAIL halt_no_issue: got rd_cycles=%0d accepts=%0d, required 0/2", rd_seen, accepts); end
    total++; if (sb.size() !== 2) begin bad++; $display("FAIL halt_enqueued: got %0d, required 2", sb.size()); end
    total++; if ({s_inst_valid, s_err} !== 2'b10) begin
      bad++; $display("FAIL halt_flags: got valid=%b err=%b, required 1/0", s_inst_valid, s_err); end
    tb_halted = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0080;
    cycle();
    redirect = 1'b0;
    cycle();
    total++; if ({s_inst_valid, s_mem_rd} !== 2'b10) begin
      bad++; $display("FAIL halt_redirect: got valid=%b rd=%b, required 1/0", s_inst_valid, s_mem_rd); end
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    total++; if (pops !== 2 || s_inst_valid !== 1'b0 || accepts !== 2 || s_err !== 1'b0) begin
      bad++; $display("FAIL halt_drain: got pops=%0d valid=%b accepts=%0d err=%b, required 2/0/2/0",
                      pops, s_inst_valid, accepts, s_err); end
  endtask

  task automatic test_err();
    do_reset();
    inst_ready = 1'b1;
    mem_stall = 1'b1;
    cycle();
    cycle();
    total++; if (s_err !== 1'b0) begin bad++; $display("FAIL err_clean: got %b, required 0", s_err); end
    mem_done = 1'b1;
    cycle();
    cycle();
    total++; if (s_err !== 1'b1) begin bad++; $display("FAIL err_spurious_done: got %b, required 1", s_err); end
    for (int i = 0; i < 5; i++) cycle();
    total++; if (s_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b, required 1", s_err); end
    do_reset();
    total++; if (s_err !== 1'b0) begin bad++; $display("FAIL err_rst_clear: got %b, required 0", s_err); end
    mem_stall = 1'b1;
    cycle();
    redirect = 1'b1; redirect_pc = 16'h0031;
    cycle();
    redirect = 1'b0;
    mem_stall = 1'b0;
    total++; if (s_mem_rd !== 1'b0) begin bad++; $display("FAIL err_redir_rd: got %b, required 0", s_mem_rd); end
    cycle();
    total++; if ({s_err, s_mem_rd, s_mem_addr} !== {1'b1, 1'b1, 16'h0030}) begin
      bad++; $display("FAIL err_odd_pc: got err=%b rd=%b addr=%h, required 1/1/0030", s_err, s_mem_rd, s_mem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_stall = 1'b1;
    cycle();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    cycle();
    redirect = 1'b0;
    mem_stall = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 30 && accepts < 2; i++) cycle();
    total++; if (accepts < 2 || {addr_log[0], addr_log[1]} !== {16'hFFFE, 16'h0000}) begin
      bad++; $display("FAIL wrap_addrs: got accepts=%0d %h %h, required FFFE 0000", accepts, addr_log[0], addr_log[1]); end
    for (int i = 0; i < 6; i++) cycle();
    total++; if (pops < 2) begin bad++; $display("FAIL wrap_pops: got %0d, required >=2", pops); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_redirect();
    test_halt();
    test_err();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Multi-cycle instruction fetch unit with a small prefetch buffer, placed directly upstream of decode. It owns the fetch PC and issues word reads to a stalling instruction memory. It buffers returned instructions with their PCs, presents them to decode under a valid/ready handshake, and flushes on branch/jump redirects. It replaces the single-cycle PC-to-memory path so the datapath can tolerate variable memory latency.

## Interface
- QDEPTH, 4: buffer entries; power of two, ≥2
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mem_addr  out  16  fetch address to instruction memory
- mem_rd  out  1  read request; held with mem_addr stable until accepted
- mem_stall  in  1  memory cannot accept this cycle
- mem_done  in  1  read data valid this cycle
- mem_data  in  16  returned instruction word
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  16  new fetch PC
- halt  in  1  HALT decoded; stop fetching (sticky until rst)
- inst_valid  out  1  head entry valid
- inst  out  16  head instruction
- inst_pc  out  16  PC of head instruction
- inst_pc_nx  out  16  inst_pc + 2, mod 2^16
- inst_ready  in  1  decode consumes head this cycle
- err  out  1  protocol error flag (sticky until rst)

## Operation
- State: fpc (16b), circular buffer of QDEPTH {pc, inst} entries, count (0..QDEPTH), FSM {IDLE, WAIT, FLUSH_WAIT, HALTED}.
- Issue condition in IDLE: !halted && !redirect && (count + 0) < QDEPTH. The check uses the registered count; a same-cycle pop is not credited. When the condition holds, mem_rd=1 and mem_addr=fpc.
- Accept = mem_rd && !mem_stall. On accept: fpc <= fpc+2 (wraps 0xFFFE→0x0000), IDLE→WAIT. A stalled request is re-presented each cycle, unchanged, until accepted.
- WAIT: mem_rd=0. On mem_done: push {pc of request, mem_data} at tail, count+1, →IDLE. If the halt latch is set, →HALTED instead.
- Pop: inst_valid && inst_ready → head advances, count−1. Push and pop in the same cycle leave count unchanged.
- Redirect has priority over push, pop and issue in that cycle:
  - count<=0, head=tail.
  - fpc <= {redirect_pc[15:1],1'b0}.
  - From WAIT, go to FLUSH_WAIT. From IDLE, go to IDLE. A stalled pending request is dropped.
  - Redirect in HALTED is ignored.
- FLUSH_WAIT: the next mem_done is discarded, then →IDLE. A further redirect here updates fpc and stays in FLUSH_WAIT.
- Halt: latched on the first cycle it is high.
  - No new issue after the latch is set.
  - An outstanding request completes and is enqueued.
  - The FSM then goes to HALTED. The buffer still drains to decode.
- err is set by any of:
  - mem_done in IDLE or HALTED
  - redirect_pc[0]=1
  - mem_stall=1 while mem_rd=0 is allowed and not an error.

## Timing
- Reset values, while rst is high and in the cycle after:
  - mem_rd=0, mem_addr=0x0000
  - inst_valid=0, inst=0x0000, inst_pc=0x0000, inst_pc_nx=0x0002
  - err=0, fpc=0x0000, count=0, state IDLE, halt latch clear
- rst mid-operation: everything returns to reset values. Any in-flight response arriving after rst is treated as IDLE mem_done and sets err; the bench must not return one.
- First cycle after rst falls: mem_rd=1, mem_addr=0x0000.
- mem_done may arrive no earlier than one cycle after accept.
- With zero stall and one-cycle memory, the first inst_valid comes 2 cycles after the first mem_rd cycle. Peak throughput is 1 instruction per 2 cycles.
- inst, inst_pc, inst_pc_nx and inst_valid are driven from registers/buffer (no combinational path from mem_data). inst_ready→pop takes effect at the next edge.
- inst_valid falls the cycle after a redirect edge.
- Full: count=QDEPTH blocks issue; no overflow is possible.
- Empty: inst_valid=0. inst_ready is ignored.

## Test plan
- Reset, memory returns 0x1111/0x2222/0x3333 with 0 stall, inst_ready=1 → mem_addr sequence 0x0000,0x0002,0x0004. inst/inst_pc pairs are {0x1111,0x0000},{0x2222,0x0002}; inst_pc_nx=0x0002 for the first.
- mem_stall held 3 cycles on the first request → mem_rd and mem_addr=0x0000 stable for 4 cycles, one accept, fpc=0x0002 afterward.
- inst_ready=0, QDEPTH=4 → exactly 4 requests issued, then mem_rd stays 0. Raising inst_ready drains the entries in order and issue resumes.
- Redirect to 0x0040 while in WAIT for 0x0006 → the 0x0006 response is discarded, count=0, next mem_addr=0x0040, first valid inst_pc=0x0040.
- halt asserted during WAIT → that response is enqueued, no further mem_rd, state HALTED, buffer drains. A later redirect has no effect.
- mem_done with no request outstanding → err=1, held until rst. redirect_pc=0x0031 → err=1, next mem_addr=0x0030.
